// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: frame candidates and code sizing.
package keypad_pkg;

    localparam int MAX_CODE_W = 6;

    typedef enum logic [1:0] {
        CAND_NONE,
        CAND_SINGLE,
        CAND_MULTI
    } cand_kind_t;

    typedef struct packed {
        cand_kind_t            kind;
        logic [MAX_CODE_W-1:0] code;
    } cand_t;

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between scanner and its consumer.
interface keypad_if
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int CODE_W = code_width(ROWS, COLS);

    logic [COLS-1:0]   col_n;
    logic [ROWS-1:0]   row_n;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_down;
    logic              multi_key;

    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_down,
        output multi_key
    );

    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  multi_key
    );

endinterface

// File: rtl/keypad_frame_debounce.sv
// Frame-level debounce: turns per-frame candidates into reported key state.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done_i,
    input  cand_t             cand_i,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    output logic              key_down_o,
    output logic              multi_key_o
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    cand_t             prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cand_kind_t        rep_q, rep_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              same, differs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= '{kind: CAND_NONE, code: '0};
            cnt_q   <= '0;
            rep_q   <= CAND_NONE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        code_d  = code_q;
        valid_d = 1'b0;
        same    = (cand_i.kind == prev_q.kind) &&
                  (cand_i.kind != CAND_SINGLE || cand_i.code == prev_q.code);
        differs = (prev_q.kind != rep_q) ||
                  (prev_q.kind == CAND_SINGLE &&
                   prev_q.code != MAX_CODE_W'(code_q));
        if (frame_done_i) begin
            prev_d = cand_i;
            if (!same)
                cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_W'(DEBOUNCE))
                cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_W'(DEBOUNCE) && differs) begin
            // Stable frame state disagrees with what was last reported.
            rep_d = prev_q.kind;
            unique case (prev_q.kind)
                CAND_SINGLE: begin
                    code_d  = prev_q.code[CODE_W-1:0];
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_down_o  = (rep_q == CAND_SINGLE);
    assign multi_key_o = (rep_q == CAND_MULTI);

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobing, column sync and frame accumulation.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 3
) (
    input  logic    clk,
    input  logic    rst,
    keypad_if.master kp
);
    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int PTR_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);

    logic [COLS-1:0]   col_s1_q, col_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ROWS-1:0]   row_n_q, row_n_d;
    logic [1:0]        acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;

    logic              sample, frame_done;
    logic [COLS-1:0]   low;
    logic [1:0]        row_cnt;
    logic [COL_W-1:0]  first_col;
    logic [CODE_W-1:0] row_code, merged_code;
    logic [2:0]        sum;
    logic [1:0]        total;
    cand_t             cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q   <= '1;
            col_s2_q   <= '1;
            div_q      <= '0;
            ptr_q      <= '0;
            row_n_q    <= ~ROWS'(1);
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else begin
            col_s1_q   <= kp.col_n;
            col_s2_q   <= col_s1_q;
            div_q      <= div_d;
            ptr_q      <= ptr_d;
            row_n_q    <= row_n_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Per-row contribution: saturating press count and lowest pressed column.
    always_comb begin
        low       = ~col_s2_q;
        row_cnt   = '0;
        first_col = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (low[c]) first_col = COL_W'(c);
        for (int c = 0; c < COLS; c++)
            if (low[c] && row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
    end

    always_comb begin
        sample      = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_done  = sample && (ptr_q == PTR_W'(ROWS - 1));
        row_code    = CODE_W'(ptr_q) * CODE_W'(COLS) + CODE_W'(first_col);
        merged_code = (acc_cnt_q == 2'd0) ? row_code : acc_code_q;
        sum         = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
        total       = (sum >= 3'd2) ? 2'd2 : sum[1:0];

        cand.kind = CAND_NONE;
        cand.code = '0;
        unique case (1'b1)
            total == 2'd1: begin
                cand.kind = CAND_SINGLE;
                cand.code = MAX_CODE_W'(merged_code);
            end
            total == 2'd2: cand.kind = CAND_MULTI;
            default: ;
        endcase
    end

    always_comb begin
        div_d      = div_q + DIV_W'(1);
        ptr_d      = ptr_q;
        row_n_d    = row_n_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (sample) begin
            div_d   = '0;
            ptr_d   = frame_done ? '0 : ptr_q + PTR_W'(1);
            row_n_d = {row_n_q[ROWS-2:0], row_n_q[ROWS-1]};
            if (frame_done) begin
                acc_cnt_d  = '0;
                acc_code_d = '0;
            end else begin
                acc_cnt_d  = total;
                acc_code_d = merged_code;
            end
        end
    end

    assign kp.row_n = row_n_q;

    keypad_frame_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CODE_W   (CODE_W)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .frame_done_i (frame_done),
        .cand_i       (cand),
        .key_code_o   (kp.key_code),
        .key_valid_o  (kp.key_valid),
        .key_down_o   (kp.key_down),
        .multi_key_o  (kp.multi_key)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a key-event scoreboard.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] keys1;
    logic [14:0] keys2;
    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    typedef struct {
        int code;
        int at;
    } ev_t;
    ev_t sb[$];

    always #5 clk = ~clk;

    keypad_if #(.ROWS(4), .COLS(4)) kif ();
    keypad_if #(.ROWS(3), .COLS(5)) kif2 ();

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    keypad_scanner #(
        .ROWS(3), .COLS(5), .SCAN_DIV(4), .DEBOUNCE(3)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .kp  (kif2.master)
    );

    // Passive key matrix: a pressed key shorts its strobed row to its column.
    always_comb begin
        kif.col_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kif.row_n[r] && keys1[r*4+c]) kif.col_n[c] = 1'b0;
    end

    always_comb begin
        kif2.col_n = '1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (!kif2.row_n[r] && keys2[r*5+c]) kif2.col_n[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) ecnt = 0;
        else     ecnt = ecnt + 1;
    end

    always @(negedge clk) begin : mon
        ev_t e;
        if (!rst && kif.key_valid) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL pulse_unexpected obs_code=%0d edge=%0d exp=none",
                       kif.key_code, ecnt);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                assert (int'(kif.key_code) === e.code) else begin
                    bad++;
                    $error("FAIL pulse_code obs=%0d exp=%0d",
                           kif.key_code, e.code);
                end
                total++;
                assert (ecnt === e.at) else begin
                    bad++;
                    $error("FAIL pulse_edge obs=%0d exp=%0d", ecnt, e.at);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    task automatic restart();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_pulse(input int code, input int at);
        ev_t e;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    initial begin
        keys1 = '0;
        keys2 = '0;
        keys2[14] = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_row_n", 32'(kif.row_n), 32'he);
        chk("rst_code", 32'(kif.key_code), 0);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_down", 32'(kif.key_down), 0);
        chk("rst_multi", 32'(kif.multi_key), 0);
        chk("rst2_row_n", 32'(kif2.row_n), 32'h6);

        // Idle scan plus the 3x5 instance holding code 14.
        rst = 1'b0;
        wait_edge(2);  chk("row0", 32'(kif.row_n), 32'he);
        wait_edge(6);  chk("row1", 32'(kif.row_n), 32'hd);
        wait_edge(10); chk("row2", 32'(kif.row_n), 32'hb);
        wait_edge(14); chk("row3", 32'(kif.row_n), 32'h7);
        wait_edge(18); chk("row_wrap", 32'(kif.row_n), 32'he);
        wait_edge(36); chk("sweep_nopulse", 32'(kif2.key_valid), 0);
        wait_edge(37);
        chk("sweep_pulse", 32'(kif2.key_valid), 1);
        chk("sweep_code", 32'(kif2.key_code), 14);
        wait_edge(60);
        chk("idle_down", 32'(kif.key_down), 0);
        chk("idle_multi", 32'(kif.multi_key), 0);
        chk("sweep_down", 32'(kif2.key_down), 1);

        // Code 15 held from reset, released after frame 4.
        keys1 = '0; keys1[15] = 1'b1;
        expect_pulse(15, 49);
        restart();
        wait_edge(50);
        chk("k15_valid_1cyc", 32'(kif.key_valid), 0);
        chk("k15_code", 32'(kif.key_code), 15);
        chk("k15_down", 32'(kif.key_down), 1);
        wait_edge(64); keys1 = '0;
        wait_edge(112); chk("k15_down_hold", 32'(kif.key_down), 1);
        wait_edge(113);
        chk("k15_released", 32'(kif.key_down), 0);
        chk("k15_code_hold", 32'(kif.key_code), 15);

        // Code 6 bouncing per frame for 4 frames, then steady.
        keys1 = '0; keys1[6] = 1'b1;
        expect_pulse(6, 113);
        restart();
        wait_edge(16); keys1[6] = 1'b0;
        wait_edge(32); keys1[6] = 1'b1;
        wait_edge(48); keys1[6] = 1'b0;
        wait_edge(64); keys1[6] = 1'b1;
        wait_edge(130);
        chk("k6_code", 32'(kif.key_code), 6);
        chk("k6_down", 32'(kif.key_down), 1);

        // Codes 0 and 5 together, then 5 released.
        keys1 = '0; keys1[0] = 1'b1; keys1[5] = 1'b1;
        restart();
        wait_edge(48); chk("multi_early", 32'(kif.multi_key), 0);
        wait_edge(49);
        chk("multi_set", 32'(kif.multi_key), 1);
        chk("multi_down", 32'(kif.key_down), 0);
        wait_edge(64); keys1[5] = 1'b0;
        expect_pulse(0, 113);
        wait_edge(114);
        chk("multi_clear", 32'(kif.multi_key), 0);
        chk("single0_down", 32'(kif.key_down), 1);
        chk("single0_code", 32'(kif.key_code), 0);

        // Code 9 accepted, then reset mid-frame with the key still held.
        keys1 = '0; keys1[9] = 1'b1;
        expect_pulse(9, 49);
        restart();
        wait_edge(57);
        chk("k9_code", 32'(kif.key_code), 9);
        #1 rst = 1'b1;
        #1;
        chk("arst_row_n", 32'(kif.row_n), 32'he);
        chk("arst_code", 32'(kif.key_code), 0);
        chk("arst_down", 32'(kif.key_down), 0);
        chk("arst_valid", 32'(kif.key_valid), 0);
        @(negedge clk);
        expect_pulse(9, 49);
        rst = 1'b0;
        wait_edge(48); chk("k9_wait_down", 32'(kif.key_down), 0);
        wait_edge(60);
        chk("k9_again_down", 32'(kif.key_down), 1);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
